// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the rv32 memory-side blocks: FSM states and transaction owner.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way pick between fetch (req0) and data (req1).
// DATA_PRIORITY_EN: data wins every tie instead of round-robin on last_owner.
module rr_arb2
  import rv32_mem_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last_owner,
  output owner_t sel,
  output logic   any
);

`ifdef DATA_PRIORITY_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  assign any = req0 | req1;

  always_comb begin
    sel = OWN_IF;
    if (req0 && req1) begin
`ifdef DATA_PRIORITY_EN
      sel = OWN_D;
`else
      sel = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
`endif
    end else if (req1) begin
      sel = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data, one transaction in flight.
// Tie-break policy selectable with DATA_PRIORITY_EN (see rr_arb2).
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner into m_*
// REQ   | m_valid high, waiting for m_ready; gnt pulses on acceptance
// RESP  | read accepted, waiting for m_rvalid to route back to owner
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int SW = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [SW-1:0] d_wstrb,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_valid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [SW-1:0] m_wstrb,
  input  logic          m_ready,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_owner_q, last_owner_d;
  owner_t sel;
  logic   any;
  logic   load;
  logic   accept;

  rr_arb2 u_arb (
    .req0       (if_req),
    .req1       (d_req),
    .last_owner (last_owner_q),
    .sel        (sel),
    .any        (any)
  );

  assign accept   = (state_q == REQ) && m_ready;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    load         = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    d_rvalid     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          load    = 1'b1;
          owner_d = sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (m_ready) begin
          if_gnt       = (owner_q == OWN_IF);
          d_gnt        = (owner_q == OWN_D);
          last_owner_d = owner_q;
          state_d      = m_we ? IDLE : RESP;
        end
      end
      RESP: begin
        if (m_rvalid) begin
          if_rvalid = (owner_q == OWN_IF);
          d_rvalid  = (owner_q == OWN_D);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // m_* come straight from flops so no req input reaches the memory port combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_D;
      m_valid      <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if (load) begin
        m_valid <= 1'b1;
        if (sel == OWN_D) begin
          m_we    <= d_we;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          m_wstrb <= d_wstrb;
        end else begin
          m_we    <= 1'b0;
          m_addr  <= if_addr;
          m_wdata <= '0;
          m_wstrb <= '0;
        end
      end else if (accept) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Requesters must hold req until their gnt; the latched transaction completes regardless
  a_if_hold : assert property (@(posedge clk) disable iff (reset)
    (state_q == REQ && owner_q == OWN_IF) |-> if_req);
  a_d_hold : assert property (@(posedge clk) disable iff (reset)
    (state_q == REQ && owner_q == OWN_D) |-> d_req);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus arbitration and reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_valid, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_valid   (m_valid),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dws;
    logic        mr;
    logic        mrv;
    logic [31:0] mrd;
    logic        ev;
    logic        ewe;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic [3:0]  ews;
    logic        eig;
    logic        eir;
    logic        edg;
    logic        edr;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Both requesters load-request; grants recorded in order (bit k = 1 means D got grant k)
  task automatic run_contend(input logic drop, input int ncyc, output int ngr, output logic [7:0] order);
    logic if_on, d_on;
    if_on = 1'b1; d_on = 1'b1; ngr = 0; order = 8'h0;
    for (int c = 0; c < ncyc; c++) begin
      if_req = if_on; if_addr = 32'h200;
      d_req = d_on; d_we = 1'b0; d_addr = 32'h2000;
      m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1234_0000 + c;
      #1;
      if (if_gnt) begin
        if (ngr < 8) order[ngr] = 1'b0;
        ngr++;
        if (drop) if_on = 1'b0;
      end
      if (d_gnt) begin
        if (ngr < 8) order[ngr] = 1'b1;
        ngr++;
        if (drop) d_on = 1'b0;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    int ngr;
    logic [7:0] order;

    vecs[0]  = '{1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,
                 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h13,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h55,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,32'h0, 1'b1,1'b1,32'h40,32'hDEADBEEF,4'b0011, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    for (int k = 6; k <= 8; k++)
      vecs[k] = '{1'b0,32'h0, 1'b1,1'b1,32'h40,32'hDEADBEEF,4'b0011, 1'b0,1'b0,32'h0,
                  1'b1,1'b1,32'h40,32'hDEADBEEF,4'b0011, 1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,32'h0, 1'b1,1'b1,32'h40,32'hDEADBEEF,4'b0011, 1'b1,1'b0,32'h0,
                 1'b1,1'b1,32'h40,32'hDEADBEEF,4'b0011, 1'b0,1'b0,1'b1,1'b0};
    vecs[10] = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h55,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b1,32'h104, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[13] = '{1'b1,32'h104, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,
                 1'b1,1'b0,32'h104,32'h0,4'h0, 1'b1,1'b0,1'b0,1'b0};
    vecs[14] = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h17,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,1'b0,1'b0};
    vecs[15] = '{1'b0,32'h0, 1'b1,1'b0,32'h2000,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[16] = '{1'b0,32'h0, 1'b1,1'b0,32'h2000,32'h0,4'h0, 1'b0,1'b1,32'h55,
                 1'b1,1'b0,32'h2000,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0};
    vecs[17] = '{1'b0,32'h0, 1'b1,1'b0,32'h2000,32'h0,4'h0, 1'b1,1'b0,32'h0,
                 1'b1,1'b0,32'h2000,32'h0,4'h0, 1'b0,1'b0,1'b1,1'b0};
    vecs[18] = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'hCAFE0001,
                 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b1};

    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    chk("rst_m_valid", 0, {31'h0, m_valid}, 32'h0);
    chk("rst_m_we",    0, {31'h0, m_we}, 32'h0);
    chk("rst_m_addr",  0, m_addr, 32'h0);
    chk("rst_m_wdata", 0, m_wdata, 32'h0);
    chk("rst_m_wstrb", 0, {28'h0, m_wstrb}, 32'h0);
    chk("rst_gnt_rv",  0, {28'h0, if_gnt, if_rvalid, d_gnt, d_rvalid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da;
      d_wdata = vecs[i].dwd; d_wstrb = vecs[i].dws;
      m_ready = vecs[i].mr; m_rvalid = vecs[i].mrv; m_rdata = vecs[i].mrd;
      #1;
      chk("m_valid",   i, {31'h0, m_valid},   {31'h0, vecs[i].ev});
      chk("if_gnt",    i, {31'h0, if_gnt},    {31'h0, vecs[i].eig});
      chk("if_rvalid", i, {31'h0, if_rvalid}, {31'h0, vecs[i].eir});
      chk("d_gnt",     i, {31'h0, d_gnt},     {31'h0, vecs[i].edg});
      chk("d_rvalid",  i, {31'h0, d_rvalid},  {31'h0, vecs[i].edr});
      if (vecs[i].ev) begin
        chk("m_we",    i, {31'h0, m_we}, {31'h0, vecs[i].ewe});
        chk("m_addr",  i, m_addr, vecs[i].ea);
        chk("m_wdata", i, m_wdata, vecs[i].ewd);
        chk("m_wstrb", i, {28'h0, m_wstrb}, {28'h0, vecs[i].ews});
      end
      if (vecs[i].eir) chk("if_rdata", i, if_rdata, vecs[i].mrd);
      if (vecs[i].edr) chk("d_rdata", i, d_rdata, vecs[i].mrd);
      @(negedge clk);
    end
    clear_inputs();

    // simultaneous requests, each requester drops after its grant
    reset_dut();
    run_contend(1'b1, 6, ngr, order);
    chk("tie_ngrants", 0, ngr, 2);
`ifdef DATA_PRIORITY_EN
    chk("tie_order", 0, {30'h0, order[1:0]}, 32'h1);
`else
    chk("tie_order", 0, {30'h0, order[1:0]}, 32'h2);
`endif

    // continuous contention, 12 cycles at one read per 3 cycles
    reset_dut();
    run_contend(1'b0, 12, ngr, order);
    chk("cont_ngrants", 0, ngr, 4);
`ifdef DATA_PRIORITY_EN
    chk("cont_order", 0, {28'h0, order[3:0]}, 32'hF);
`else
    chk("cont_order", 0, {28'h0, order[3:0]}, 32'hA);
`endif

    // async reset while a fetch waits in RESP, then a stale m_rvalid
    reset_dut();
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    chk("rr_gnt", 0, {31'h0, if_gnt}, 32'h1);
    @(negedge clk);
    if_req = 1'b0; m_ready = 1'b0;
    #1;
    chk("rr_addr_before", 0, m_addr, 32'h300);
    #2;
    reset = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h77;
    #1;
    chk("rr_m_addr",   0, m_addr, 32'h0);
    chk("rr_m_valid",  0, {31'h0, m_valid}, 32'h0);
    chk("rr_if_rv_in", 0, {31'h0, if_rvalid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rr_if_rvalid", c, {31'h0, if_rvalid}, 32'h0);
      chk("rr_d_rvalid",  c, {31'h0, d_rvalid}, 32'h0);
      chk("rr_m_valid2",  c, {31'h0, m_valid}, 32'h0);
      @(negedge clk);
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
